sym_fir_ctrl: RTL and testbench

Sequencer and configuration port for the BRAM-backed symmetric FIR section. Accepts one input sample per handshake and writes it into the delay-line BRAM. It then walks the tap pairs (x[n-k], x[n-(TAPS-1-k)]) with the matching coefficient address and frames the external pre-add/MAC datapath. It also serialises coefficient updates and delay-line flushes so that neither collides with an active filter pass.

---
 rtl/sym_fir_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sym_fir_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_ctrl.sv
// Sequencer for a BRAM-backed symmetric FIR: delay-line writes, tap-pair address walk,
// MAC framing, and serialisation of coefficient writes and delay-line flushes.
module sym_fir_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 18,
  parameter int unsigned TAPS     = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned PIPE_LAT = 3,
  localparam int unsigned H       = TAPS / 2,
  localparam int unsigned CADDR_W = $clog2(H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [CADDR_W-1:0] cfg_addr,
  input  logic [COEF_W-1:0]  cfg_data,
  input  logic               flush,
  output logic               busy,
  output logic               dl_we,
  output logic [ADDR_W-1:0]  dl_waddr,
  output logic [DATA_W-1:0]  dl_wdata,
  output logic [ADDR_W-1:0]  dl_raddr_a,
  output logic [ADDR_W-1:0]  dl_raddr_b,
  output logic               coef_we,
  output logic [CADDR_W-1:0] coef_waddr,
  output logic [COEF_W-1:0]  coef_wdata,
  output logic [CADDR_W-1:0] coef_raddr,
  output logic               mac_en,
  output logic               mac_first,
  output logic               mac_last,
  output logic               res_valid
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned CNT_MAX = (DEPTH > PIPE_LAT) ? DEPTH : PIPE_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {StIdle, StFlush, StWrite, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  wr_ptr_q, base_q, tap_k;
  logic [DATA_W-1:0]  sample_q;
  logic               flush_pend_q;
  logic               coef_we_q;
  logic [CADDR_W-1:0] coef_waddr_q;
  logic [COEF_W-1:0]  coef_wdata_q;
  logic               cfg_hs, s_hs, cfg_in_range;
  logic               flush_done, run_done, drain_done;

  assign cfg_hs     = cfg_we & cfg_ready;
  assign s_hs       = s_valid & s_ready;
  assign flush_done = (cnt_q == CNT_W'(DEPTH - 1));
  assign run_done   = (cnt_q == CNT_W'(H - 1));
  assign drain_done = (cnt_q == CNT_W'(PIPE_LAT - 1));
  assign tap_k      = cnt_q[ADDR_W-1:0];

  // With a power-of-two H every representable index is in range.
  if (H == (2 ** CADDR_W)) begin : g_cfg_full
    assign cfg_in_range = 1'b1;
  end else begin : g_cfg_part
    assign cfg_in_range = (32'(cfg_addr) < H);
  end

  // Reset lands directly in the flush so s_ready rises exactly DEPTH cycles after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFlush;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (flush || flush_pend_q) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else if (s_hs) begin
          state_d = StWrite;
        end
      end
      StFlush: begin
        if (flush_done) state_d = StIdle;
        else            cnt_d   = cnt_q + 1'b1;
      end
      StWrite: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (run_done) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StIdle;
        else            cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      base_q       <= '0;
      sample_q     <= '0;
      flush_pend_q <= 1'b1;
      coef_we_q    <= 1'b0;
      coef_waddr_q <= '0;
      coef_wdata_q <= '0;
    end else begin
      if (s_hs) sample_q <= s_data;
      if (state_q == StWrite) begin
        base_q   <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (state_q == StFlush && flush_done) begin
        wr_ptr_q     <= '0;
        flush_pend_q <= 1'b0;
      end else if (flush && (state_q inside {StWrite, StRun, StDrain})) begin
        flush_pend_q <= 1'b1;
      end
      coef_we_q <= cfg_hs & cfg_in_range;
      if (cfg_hs) begin
        coef_waddr_q <= cfg_addr;
        coef_wdata_q <= cfg_data;
      end
    end
  end

  always_comb begin
    s_ready    = 1'b0;
    cfg_ready  = 1'b0;
    busy       = 1'b0;
    dl_we      = 1'b0;
    dl_waddr   = '0;
    dl_wdata   = '0;
    dl_raddr_a = '0;
    dl_raddr_b = '0;
    coef_we    = 1'b0;
    coef_waddr = '0;
    coef_wdata = '0;
    coef_raddr = '0;
    mac_en     = 1'b0;
    mac_first  = 1'b0;
    mac_last   = 1'b0;
    res_valid  = 1'b0;
    if (!rst) begin
      busy      = (state_q != StIdle) | flush_pend_q;
      cfg_ready = (state_q == StIdle) & ~flush_pend_q & ~flush;
      s_ready   = cfg_ready & ~cfg_we;
      if (coef_we_q) begin
        coef_we    = 1'b1;
        coef_waddr = coef_waddr_q;
        coef_wdata = coef_wdata_q;
      end
      case (state_q)
        StFlush: begin
          dl_we    = 1'b1;
          dl_waddr = cnt_q[ADDR_W-1:0];
        end
        StWrite: begin
          dl_we    = 1'b1;
          dl_waddr = wr_ptr_q;
          dl_wdata = sample_q;
        end
        StRun: begin
          dl_raddr_a = base_q - tap_k;
          dl_raddr_b = base_q - (ADDR_W'(TAPS - 1) - tap_k);
          coef_raddr = cnt_q[CADDR_W-1:0];
          mac_en     = 1'b1;
          mac_first  = (cnt_q == '0);
          mac_last   = run_done;
        end
        StDrain: res_valid = drain_done;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_ctrl.sv
// Directed bench for sym_fir_ctrl: flush, tap-pair walk, back-to-back samples, coefficient
// writes, flush during a pass and reset mid-pass. A second instance (H = 20) covers dropped writes.
module tb_sym_fir_ctrl;
  localparam int DEPTH    = 64;
  localparam int TAPS     = 32;
  localparam int H        = 16;
  localparam int PIPE_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, cfg_we, flush;
  logic [15:0] s_data;
  logic [3:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic        s_ready, cfg_ready, busy, dl_we, coef_we, mac_en, mac_first, mac_last, res_valid;
  logic [5:0]  dl_waddr, dl_raddr_a, dl_raddr_b;
  logic [15:0] dl_wdata;
  logic [3:0]  coef_waddr, coef_raddr;
  logic [17:0] coef_wdata;

  logic        cfg_we2;
  logic [4:0]  cfg_addr2;
  logic [17:0] cfg_data2;
  logic        s_ready2, cfg_ready2, busy2, dl_we2, coef_we2, mac_en2, mac_first2, mac_last2;
  logic        res_valid2;
  logic [5:0]  dl_waddr2, dl_raddr_a2, dl_raddr_b2;
  logic [15:0] dl_wdata2;
  logic [4:0]  coef_waddr2, coef_raddr2;
  logic [17:0] coef_wdata2;

  int nvec = 0;
  int nerr = 0;

  sym_fir_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .flush(flush), .busy(busy), .dl_we(dl_we), .dl_waddr(dl_waddr), .dl_wdata(dl_wdata),
    .dl_raddr_a(dl_raddr_a), .dl_raddr_b(dl_raddr_b), .coef_we(coef_we),
    .coef_waddr(coef_waddr), .coef_wdata(coef_wdata), .coef_raddr(coef_raddr),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last), .res_valid(res_valid)
  );

  sym_fir_ctrl #(.TAPS(40)) dut2 (
    .clk(clk), .rst(rst), .s_valid(1'b0), .s_ready(s_ready2), .s_data(16'h0000),
    .cfg_we(cfg_we2), .cfg_ready(cfg_ready2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .flush(1'b0), .busy(busy2), .dl_we(dl_we2), .dl_waddr(dl_waddr2), .dl_wdata(dl_wdata2),
    .dl_raddr_a(dl_raddr_a2), .dl_raddr_b(dl_raddr_b2), .coef_we(coef_we2),
    .coef_waddr(coef_waddr2), .coef_wdata(coef_wdata2), .coef_raddr(coef_raddr2),
    .mac_en(mac_en2), .mac_first(mac_first2), .mac_last(mac_last2), .res_valid(res_valid2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first flush cycle; returns #1 into the first idle cycle.
  task automatic flush_check();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("flush_busy", busy, 1);
      chk("flush_we", dl_we, 1);
      chk("flush_addr", dl_waddr, i);
      chk("flush_data", dl_wdata, 0);
      chk("flush_sready", s_ready, 0);
      chk("flush_res", res_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("post_flush_sready", s_ready, 1);
    chk("post_flush_busy", busy, 0);
    chk("post_flush_we", dl_we, 0);
  endtask

  // Handshake in cycle 0; returns at the negedge of cycle H+2+PIPE_LAT (back in IDLE).
  task automatic do_pass(input logic [5:0] base, input logic [15:0] data, input bit hold,
                         input int flush_k);
    logic [5:0] ea, eb;
    s_valid = 1'b1;
    s_data  = data;
    #1;
    chk("hs_sready", s_ready, 1);
    @(negedge clk);
    s_valid = hold;
    #1;
    chk("wr_we", dl_we, 1);
    chk("wr_addr", dl_waddr, base);
    chk("wr_data", dl_wdata, data);
    chk("wr_busy", busy, 1);
    chk("wr_sready", s_ready, 0);
    chk("wr_coef_we", coef_we, 0);
    chk("wr_mac_en", mac_en, 0);
    for (int k = 0; k < H; k++) begin
      @(negedge clk);
      flush = (k == flush_k);
      #1;
      ea = base - 6'(k);
      eb = base - 6'(TAPS - 1 - k);
      chk("run_en", mac_en, 1);
      chk("run_first", mac_first, (k == 0));
      chk("run_last", mac_last, (k == H - 1));
      chk("run_raddr_a", dl_raddr_a, ea);
      chk("run_raddr_b", dl_raddr_b, eb);
      chk("run_coef_raddr", coef_raddr, k);
      chk("run_dl_we", dl_we, 0);
      chk("run_sready", s_ready, 0);
      chk("run_res", res_valid, 0);
    end
    for (int d = 0; d < PIPE_LAT; d++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("drain_en", mac_en, 0);
      chk("drain_res", res_valid, (d == PIPE_LAT - 1));
      chk("drain_sready", s_ready, 0);
      chk("drain_busy", busy, 1);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    flush = 1'b0; cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_data2 = '0;

    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_dl_we", dl_we, 0);
      chk("rst_sready", s_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
    end

    @(negedge clk);
    rst = 1'b0;
    flush_check();

    // Out-of-range index (H = 20) is accepted but dropped; index 19 is written.
    cfg_we2 = 1'b1; cfg_addr2 = 5'd20; cfg_data2 = 18'h15555;
    #1;
    chk("cfg2_ready_drop", cfg_ready2, 1);
    @(negedge clk);
    cfg_we2 = 1'b0;
    #1;
    chk("cfg2_dropped", coef_we2, 0);
    cfg_we2 = 1'b1; cfg_addr2 = 5'd19; cfg_data2 = 18'h2AAAA;
    #1;
    chk("cfg2_ready_ok", cfg_ready2, 1);
    @(negedge clk);
    cfg_we2 = 1'b0;
    #1;
    chk("cfg2_we", coef_we2, 1);
    chk("cfg2_waddr", coef_waddr2, 19);
    chk("cfg2_wdata", coef_wdata2, 18'h2AAAA);
    @(negedge clk);
    #1;
    chk("cfg2_we_pulse", coef_we2, 0);

    // First sample: k=0 pair (0,33), k=15 pair (49,48).
    do_pass(6'd0, 16'h0100, 1'b0, -1);

    // 70 back-to-back samples with s_valid held; j = 64 is the 65th sample overall (addr 0).
    for (int j = 1; j <= 70; j++) begin
      do_pass(6'(j), 16'(j * 16'h0123), (j < 70), -1);
    end
    s_valid = 1'b0;

    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 18'h1FFFF; s_valid = 1'b1; s_data = 16'hBEEF;
    #1;
    chk("cfg_ready", cfg_ready, 1);
    chk("cfg_blocks_sready", s_ready, 0);
    chk("cfg_we_early", coef_we, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    chk("cfg_we", coef_we, 1);
    chk("cfg_waddr", coef_waddr, 3);
    chk("cfg_wdata", coef_wdata, 18'h1FFFF);
    chk("cfg_busy", busy, 0);
    do_pass(6'd7, 16'hBEEF, 1'b0, -1);

    do_pass(6'd8, 16'h1234, 1'b0, 7);
    #1;
    chk("pend_sready", s_ready, 0);
    chk("pend_cfg_ready", cfg_ready, 0);
    chk("pend_busy", busy, 1);
    chk("pend_dl_we", dl_we, 0);
    @(negedge clk);
    flush_check();
    do_pass(6'd0, 16'h5678, 1'b0, -1);

    s_valid = 1'b1; s_data = 16'h9999;
    #1;
    chk("rr_hs", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("rr_waddr", dl_waddr, 1);
    for (int k = 0; k <= 4; k++) @(negedge clk);
    #1;
    chk("rr_k4_en", mac_en, 1);
    chk("rr_k4_raddr_a", dl_raddr_a, 6'd61);
    rst = 1'b1;
    repeat (2) begin
      #1;
      chk("rr_mac_en", mac_en, 0);
      chk("rr_raddr_a", dl_raddr_a, 0);
      chk("rr_coef_raddr", coef_raddr, 0);
      chk("rr_res", res_valid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_dl_we", dl_we, 0);
      chk("rr_sready", s_ready, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    flush_check();
    do_pass(6'd0, 16'hA5A5, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
